// File: rtl/kb_event_fifo.sv
// Keyboard event queue: turns kb_driver key levels into press/repeat events and presents the FIFO head as the CPU keyboard word.
// Typematic auto-repeat is built only when KB_REPEAT_EN is defined.
module kb_event_fifo #(
   parameter int unsigned DEPTH_LOG2    = 3,
   parameter int unsigned DELAY_CYCLES  = 25000000,
   parameter int unsigned REPEAT_CYCLES = 12500000
) (
   input  logic                  CLOCK_50,
   input  logic                  rst,
   input  logic [7:0]            ascii,
   input  logic [4:0]            flags,
   input  logic                  rd_en,
   output logic [31:0]           kb_word,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int unsigned           DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   localparam logic [2:0] S_IDLE   = 3'b001;
   localparam logic [2:0] S_DELAY  = 3'b010;
`ifdef KB_REPEAT_EN
   localparam logic [2:0] S_REPEAT = 3'b100;
`endif

   // The timer starts at 1, so an interval of 0 would never match.
   if (DELAY_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_interval
      $error("kb_event_fifo: DELAY_CYCLES and REPEAT_CYCLES must be at least 1");
   end

   logic [7:0]             ascii_q;
   logic [2:0]             state_q, state_d;
   logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]    count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic [12:0]            mem_q [DEPTH];
   logic [12:0]            mem_d [DEPTH];
   logic                   press, push, push_ok, pop_ok;
   logic [12:0]            head;
`ifdef KB_REPEAT_EN
   logic [31:0]            timer_q, timer_d;
`endif

   assign press = (ascii != 8'd0) && (ascii != ascii_q);

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
`ifdef KB_REPEAT_EN
      timer_d = timer_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (press) begin
               push    = 1'b1;
               state_d = S_DELAY;
`ifdef KB_REPEAT_EN
               timer_d = 32'd1;
`endif
            end
         end
`ifdef KB_REPEAT_EN
         S_DELAY, S_REPEAT: begin
`else
         S_DELAY: begin
`endif
            // Release wins over everything, then a new key, then the repeat timer.
            if (ascii == 8'd0) begin
               state_d = S_IDLE;
            end else if (press) begin
               push    = 1'b1;
               state_d = S_DELAY;
`ifdef KB_REPEAT_EN
               timer_d = 32'd1;
            end else if (timer_q == ((state_q == S_DELAY) ? 32'(DELAY_CYCLES)
                                                          : 32'(REPEAT_CYCLES))) begin
               push    = 1'b1;
               state_d = S_REPEAT;
               timer_d = 32'd1;
            end else begin
               timer_d = timer_q + 32'd1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop_ok     = rd_en && (count_q != '0);
      // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
      push_ok    = push && ((count_q != DEPTH_CNT) || pop_ok);
      overflow_d = rd_en ? 1'b0 : (overflow_q | (push & ~push_ok));
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mem_d      = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = {flags, ascii};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         ascii_q    <= 8'd0;
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         mem_q      <= '{default: '0};
`ifdef KB_REPEAT_EN
         timer_q    <= 32'd0;
`endif
      end else begin
         ascii_q    <= ascii;
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
`ifdef KB_REPEAT_EN
         timer_q    <= timer_d;
`endif
      end
   end

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_CNT);
   assign count   = count_q;
   assign head    = empty ? 13'd0 : mem_q[rd_ptr_q];
   assign kb_word = {~empty, overflow_q, 17'd0, head};

endmodule

// File: tb/tb_kb_event_fifo.sv
// Bench for kb_event_fifo: vector table for press/change timing, scoreboard queue for FIFO contents.
module tb_kb_event_fifo;

   logic        CLOCK_50 = 1'b0;
   logic        rst      = 1'b1;
   logic [7:0]  ascii    = 8'd0;
   logic [4:0]  flags    = 5'd0;
   logic        rd_en    = 1'b0;
   logic [31:0] kb_word;
   logic        empty, full;
   logic [2:0]  count;

   kb_event_fifo #(.DEPTH_LOG2(2), .DELAY_CYCLES(10), .REPEAT_CYCLES(4)) dut (
      .CLOCK_50 (CLOCK_50),
      .rst      (rst),
      .ascii    (ascii),
      .flags    (flags),
      .rd_en    (rd_en),
      .kb_word  (kb_word),
      .empty    (empty),
      .full     (full),
      .count    (count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic [7:0]  a;
      logic [4:0]  f;
      logic        rd;
      logic [2:0]  cnt;
      logic [31:0] word;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [12:0] sb[$];
   logic        ovf_exp = 1'b0;
   vec_t        vecs [22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Compare the head against the scoreboard front, then pop it.
   task automatic pop_chk(input string name);
      logic [12:0] e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty actual=%h required=entry", name, kb_word);
         return;
      end
      e = sb.pop_front();
      chk(name, kb_word, {1'b1, ovf_exp, 17'd0, e});
      rd_en = 1'b1;
      step();
      rd_en   = 1'b0;
      ovf_exp = 1'b0;
   endtask

   initial begin
      logic        got;
      logic [12:0] e;
      int          exp_cnt;

      vecs = '{
         '{8'h61, 5'b00001, 1'b0, 3'd1, 32'h8000_0161},
         '{8'h61, 5'b00001, 1'b0, 3'd1, 32'h8000_0161},
         '{8'h61, 5'b00001, 1'b0, 3'd1, 32'h8000_0161},
         '{8'h61, 5'b00001, 1'b0, 3'd1, 32'h8000_0161},
         '{8'h61, 5'b00001, 1'b0, 3'd1, 32'h8000_0161},
         '{8'h00, 5'b00000, 1'b0, 3'd1, 32'h8000_0161},
         '{8'h00, 5'b00000, 1'b1, 3'd0, 32'h0000_0000},
         '{8'h31, 5'b00000, 1'b0, 3'd1, 32'h8000_0031},
         '{8'h31, 5'b00000, 1'b0, 3'd1, 32'h8000_0031},
         '{8'h31, 5'b00000, 1'b0, 3'd1, 32'h8000_0031},
         '{8'h32, 5'b00000, 1'b0, 3'd2, 32'h8000_0031},
         '{8'h32, 5'b00000, 1'b1, 3'd1, 32'h8000_0032},
         '{8'h32, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h32, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h32, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h32, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h32, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h32, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h32, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h32, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h00, 5'b00000, 1'b0, 3'd1, 32'h8000_0032},
         '{8'h00, 5'b00000, 1'b1, 3'd0, 32'h0000_0000}
      };

      // Reset with a key held
      rst   = 1'b1;
      ascii = 8'h41;
      step();
      step();
      chk("rst_word",  kb_word, 32'h0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      rst = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 2 && !got; i++) begin
         step();
         if (kb_word == 32'h8000_0041) got = 1'b1;
      end
      chk("rst_fresh_press", 32'(got), 32'd1);
      chk("rst_fresh_count", 32'(count), 32'd1);
      ascii = 8'h00;
      step();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("rst_pop_empty", 32'(empty), 32'd1);

      // Single press and direct key change, cycle by cycle
      for (int i = 0; i < 22; i++) begin
         ascii = vecs[i].a;
         flags = vecs[i].f;
         rd_en = vecs[i].rd;
         step();
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d_word", i),  kb_word, vecs[i].word);
      end
      rd_en = 1'b0;
      flags = 5'd0;

      // Long hold
      ascii = 8'h20;
      for (int i = 0; i < 30; i++) step();
      ascii = 8'h00;
      step();
`ifdef KB_REPEAT_EN
      for (int i = 0; i < 4; i++) sb.push_back(13'h020);
      ovf_exp = 1'b1;
      exp_cnt = 4;
`else
      sb.push_back(13'h020);
      ovf_exp = 1'b0;
      exp_cnt = 1;
`endif
      chk("hold_count", 32'(count), 32'(exp_cnt));
      chk("hold_ovf",   32'(kb_word[30]), 32'(ovf_exp));
      while (sb.size() != 0) pop_chk("hold_pop");
      chk("hold_drained_word", kb_word, 32'h0);
      chk("hold_drained_empty", 32'(empty), 32'd1);

      // Fill, overflow, then simultaneous push/pop while full
      for (int k = 0; k < 4; k++) begin
         ascii = 8'h11 + 8'(k);
         sb.push_back({5'd0, ascii});
         step();
      end
      chk("fill_full",  32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd4);
      ascii = 8'h16;
      step();
      ovf_exp = 1'b1;
      chk("drop_count", 32'(count), 32'd4);
      chk("drop_ovf",   32'(kb_word[30]), 32'd1);
      e = sb.pop_front();
      chk("pushpop_head_before", kb_word, {1'b1, ovf_exp, 17'd0, e});
      ascii = 8'h15;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      ovf_exp = 1'b0;
      sb.push_back(13'h015);
      chk("pushpop_count", 32'(count), 32'd4);
      chk("pushpop_ovf",   32'(kb_word[30]), 32'd0);
      chk("pushpop_full",  32'(full), 32'd1);
      ascii = 8'h00;
      step();
      while (sb.size() != 0) pop_chk("full_pop");

      // Pop while empty, then push and pop together while empty
      rd_en = 1'b1;
      step();
      chk("empty_pop_count", 32'(count), 32'd0);
      chk("empty_pop_word",  kb_word, 32'h0);
      ascii = 8'h22;
      step();
      rd_en = 1'b0;
      chk("empty_pushpop_count", 32'(count), 32'd1);
      chk("empty_pushpop_word",  kb_word, 32'h8000_0022);
      ascii = 8'h00;
      step();
      sb.push_back(13'h022);
      pop_chk("empty_pushpop_pop");
      chk("empty_pushpop_drained", 32'(empty), 32'd1);

      // Reset in the middle of a hold
      ascii = 8'h41;
      step();
      chk("midrst_pre_count", 32'(count), 32'd1);
      rst = 1'b1;
      step();
      chk("midrst_word",  kb_word, 32'h0);
      chk("midrst_count", 32'(count), 32'd0);
      rst = 1'b0;
      step();
      chk("midrst_fresh_word", kb_word, 32'h8000_0041);
      ascii = 8'h00;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kb_event_fifo.md
# kb_event_fifo

Keyboard event queue between `kb_driver` and `memory_map`. Converts the level-style `ascii`/modifier outputs of the PS/2 driver into discrete key events, with typematic auto-repeat. Buffers events in a small FIFO. Presents the head entry as the 32-bit keyboard register word read by the CPU; a CPU read pops the entry, so software sees every keystroke exactly once.

## Interface
Parameters:
- `DEPTH_LOG2`, 3 — FIFO depth is 2^DEPTH_LOG2 entries (8).
- `DELAY_CYCLES`, 25000000 — cycles from press event to first repeat (500 ms at 50 MHz).
- `REPEAT_CYCLES`, 12500000 — cycles between repeats (250 ms).

Ports:
- `CLOCK_50`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ascii`  in  8  current key from `kb_driver`; 0 means no key held.
- `flags`  in  5  {is_error, is_special, is_capital, is_ctrl, is_shift} from `kb_driver`.
- `rd_en`  in  1  single-cycle pop strobe, asserted by `memory_map` when the CPU reads the keyboard register.
- `kb_word`  out  32  {valid, overflow, 17'd0, head_flags[4:0], head_ascii[7:0]}; bits [12:0] are 0 when empty.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `count`  out  DEPTH_LOG2+1  number of stored entries.

## Operation
- Entry format: 13 bits {flags, ascii}. The entry is sampled from the inputs in the same cycle as the push.
- `ascii_q` is `ascii` registered every cycle.
- Press event: `ascii != 0 && ascii != ascii_q`.
  - Covers the 0→key transition and a direct key→different-key transition.
  - Release (`ascii` = 0) produces no entry.
- State machine, one-hot, with a 32-bit `timer`:
  - IDLE: on a press event, push and go to DELAY with `timer` = 1.
  - DELAY:
    - If `ascii` = 0, go to IDLE.
    - On a new press event, push and restart DELAY with `timer` = 1.
    - When `timer` == DELAY_CYCLES, push a repeat and go to REPEAT with `timer` = 1.
    - Otherwise increment `timer`.
  - REPEAT: same release and new-press rules as DELAY. When `timer` == REPEAT_CYCLES, push and set `timer` = 1.
- FIFO: circular buffer with read and write pointers of DEPTH_LOG2 bits (wrap modulo depth) and a separate `count`.
  - Push while full: the entry is dropped and `overflow` is set. `overflow` is sticky.
  - Pop (`rd_en`) while empty: ignored; pointers and `count` are unchanged.
  - Push and pop in the same cycle while full: both execute. `count` stays at max and no overflow is flagged.
  - Push and pop in the same cycle while empty: push only. The pop is ignored and `count` becomes 1.
  - `rd_en` clears `overflow` in the same cycle, whether or not the FIFO is empty.
- `kb_word[31]` = !empty. `kb_word[30]` = overflow.

## Timing
- Reset values:
  - FIFO empty, pointers 0, `count` 0, `overflow` 0.
  - State IDLE, `timer` 0, `ascii_q` 0.
  - Outputs: `kb_word` 0, `empty` 1, `full` 0.
- A key held through reset yields a fresh press event on the first cycle after `rst` deasserts.
- Push latency: an event detected in cycle N is visible on `kb_word`/`count` after edge N+1.
- `kb_word` is a registered-state mux: `empty`/`full`/`count` decode from registers, with no combinational path from `ascii` or `rd_en`.
- After a pop at edge N, the next entry (or 0) appears immediately after edge N.
- First repeat is pushed DELAY_CYCLES cycles after the press push. Later repeats follow every REPEAT_CYCLES cycles.
- Reset asserted mid-hold or mid-repeat discards all entries and returns to IDLE the same edge.

## Configuration
- `KB_REPEAT_EN`
  - Defined: typematic repeat as described above.
  - Undefined: REPEAT state and repeat pushes are removed. DELAY only waits for release or a new press, and `timer` is not built. Exactly one entry per press event.

## Test plan
Bench parameters: DEPTH_LOG2 = 2, DELAY_CYCLES = 10, REPEAT_CYCLES = 4.
- Reset check: pulse `rst` with `ascii` = 8'h41 held → `kb_word` = 0 during reset; after release, `kb_word` = 32'h8000_0041 within 2 cycles and `count` = 1.
- Single press: `ascii` = 8'h61, `flags` = 5'b00001, held 5 cycles then 0 → exactly one entry `kb_word` = 32'h8000_0161; `rd_en` pulse → `kb_word` = 0, `empty` = 1.
- Repeat (with `KB_REPEAT_EN`): hold 8'h20 for 30 cycles → pushes at press +0, +10, +14, +18, +22, +26; the 5th and 6th are dropped, `count` = 4, `kb_word[30]` = 1. First `rd_en` clears overflow.
- Key change: 8'h31 for 3 cycles, then 8'h32 directly → two entries 31, 32; no repeat before 10 cycles after the 32 press.
- Full with simultaneous push and `rd_en` → `count` stays 4, `overflow` stays 0, head advances. `rd_en` on empty → pointers and `count` unchanged.
- Without `KB_REPEAT_EN`: hold 8'h20 for 30 cycles → `count` = 1.
